// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// Forwarding and hazard control for a classic 5-stage pipeline. The block keeps
// its own shadow copies of the ID/EX, EX/MEM and MEM/WB register-index fields.
// From these copies and the ID-stage inputs it derives the operand-forward
// selects and the stall/flush controls.
//
// Ports
//   clk_i               clock, rising edge
//   rst_i               asynchronous reset, active low
//   id_rs_i/id_rt_i     source register indices of the instruction in ID
//   id_rd_i             final destination index of the ID instruction
//   id_regwrite_i       ID instruction writes the register file
//   id_memread_i        ID instruction is a load
//   id_use_rs_i/_rt_i   ID instruction actually reads rs / rt
//   ex_branch_taken_i   branch in EX resolved taken this cycle
//   fwd_a_o/fwd_b_o     EX operand mux selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   pc_write_o          PC update enable
//   ifid_write_o        IF/ID register enable
//   bubble_o            zero ID/EX control this cycle
//   flush_o             zero IF/ID and ID/EX this cycle
//   stall_cnt_o         saturating count of load-use stall cycles (registered)
//
// All outputs other than stall_cnt_o are combinational. They depend only on the
// shadow state and the current inputs, so they take effect in the same cycle.
module hazard_forward_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_regwrite_i,
    input  logic       id_memread_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic       ex_branch_taken_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       bubble_o,
    output logic       flush_o,
    output logic [7:0] stall_cnt_o
);

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned CNT_W     = 8;

    localparam logic [SEL_W-1:0]     FWD_RF  = 2'b00;
    localparam logic [SEL_W-1:0]     FWD_MEM = 2'b01;
    localparam logic [SEL_W-1:0]     FWD_WB  = 2'b10;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    // Shadow of the ID/EX fields that hazard detection needs
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } ex_stage_t;

    // Shadow of a write-back-capable later stage
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
    } wr_stage_t;

    ex_stage_t        ex_q,  ex_d;
    wr_stage_t        mem_q, mem_d;
    wr_stage_t        wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use_c;

    // Operand forward select; the EX/MEM stage is checked first so the newest value wins
    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic [REG_IDX_W-1:0] src,
        input wr_stage_t            mem_s,
        input wr_stage_t            wb_s
    );
        logic [SEL_W-1:0] sel;
        sel = FWD_RF;
        if (mem_s.regwrite && (mem_s.rd != REG_ZERO) && (mem_s.rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_s.regwrite && (wb_s.rd != REG_ZERO) && (wb_s.rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_c = 1'b0;
        if (ex_q.memread && (ex_q.rd != REG_ZERO)) begin
            load_use_c = (id_use_rs_i && (id_rs_i == ex_q.rd)) ||
                         (id_use_rt_i && (id_rt_i == ex_q.rd));
        end
    end

    // Forwarding selects; reset clears the shadows, so these read 00 in reset
    always_comb begin
        fwd_a_o = fwd_sel(ex_q.rs, mem_q, wb_q);
        fwd_b_o = fwd_sel(ex_q.rt, mem_q, wb_q);
    end

    // Pipeline control: reset overrides everything, then taken branch, then load-use
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        bubble_o     = 1'b0;
        flush_o      = 1'b0;
        if (!rst_i) begin
            pc_write_o   = 1'b1;
        end else if (ex_branch_taken_i) begin
            flush_o      = 1'b1;
        end else if (load_use_c) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
        end
    end

    // Shadow pipeline advance; a bubble or flush inserts an all-zero EX entry
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        if (!(bubble_o || flush_o)) begin
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        wb_d           = mem_q;
    end

    // Saturating stall counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl: table of per-cycle ID instructions with
// hand-derived expected outputs, plus directed saturation and reset sequences.
module tb_hazard_forward_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i, id_rd_i;
    logic       id_regwrite_i, id_memread_i, id_use_rs_i, id_use_rt_i;
    logic       ex_branch_taken_i;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       pc_write_o, ifid_write_o, bubble_o, flush_o;
    logic [7:0] stall_cnt_o;

    hazard_forward_ctrl dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .id_rd_i           (id_rd_i),
        .id_regwrite_i     (id_regwrite_i),
        .id_memread_i      (id_memread_i),
        .id_use_rs_i       (id_use_rs_i),
        .id_use_rt_i       (id_use_rt_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o),
        .pc_write_o        (pc_write_o),
        .ifid_write_o      (ifid_write_o),
        .bubble_o          (bubble_o),
        .flush_o           (flush_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       rw, mr, urs, urt, br;
        logic [1:0] fa, fb;
        logic       stall, flush;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        string      name;
        logic       chk_fwd;
        logic [1:0] fa, fb;
        logic       stall, flush;
        logic [7:0] cnt;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t tbl[22];

    function automatic vec_t mk(input int rs, input int rt, input int rd,
                                input bit rw, input bit mr, input bit urs, input bit urt,
                                input bit br, input int fa, input int fb,
                                input bit stall, input bit flush, input int cnt);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.rw = rw; v.mr = mr; v.urs = urs; v.urt = urt; v.br = br;
        v.fa = 2'(fa); v.fb = 2'(fb);
        v.stall = stall; v.flush = flush; v.cnt = 8'(cnt);
        return v;
    endfunction

    function automatic vec_t nop(input int fa, input int fb, input int cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, fa, fb, 0, 0, cnt);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one ID instruction after the edge and queue its expected outputs
    task automatic drive(input vec_t v, input string name, input bit chk_fwd);
        exp_t e;
        @(posedge clk_i);
        #1;
        id_rs_i = v.rs; id_rt_i = v.rt; id_rd_i = v.rd;
        id_regwrite_i = v.rw; id_memread_i = v.mr;
        id_use_rs_i = v.urs; id_use_rt_i = v.urt;
        ex_branch_taken_i = v.br;
        e.name = name; e.chk_fwd = chk_fwd;
        e.fa = v.fa; e.fb = v.fb; e.stall = v.stall; e.flush = v.flush; e.cnt = v.cnt;
        sb_q.push_back(e);
    endtask

    // Pop the expectation and compare on the falling edge
    task automatic sample();
        exp_t e;
        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.chk_fwd) begin
                chk({e.name, ".fwd_a"}, 8'(fwd_a_o), 8'(e.fa));
                chk({e.name, ".fwd_b"}, 8'(fwd_b_o), 8'(e.fb));
            end
            chk({e.name, ".pc_write"},   8'(pc_write_o),   8'(!e.stall));
            chk({e.name, ".ifid_write"}, 8'(ifid_write_o), 8'(!e.stall));
            chk({e.name, ".bubble"},     8'(bubble_o),     8'(e.stall));
            chk({e.name, ".flush"},      8'(flush_o),      8'(e.flush));
            chk({e.name, ".stall_cnt"},  stall_cnt_o,      e.cnt);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".fwd_a"},      8'(fwd_a_o),      8'd0);
        chk({name, ".fwd_b"},      8'(fwd_b_o),      8'd0);
        chk({name, ".pc_write"},   8'(pc_write_o),   8'd1);
        chk({name, ".ifid_write"}, 8'(ifid_write_o), 8'd1);
        chk({name, ".bubble"},     8'(bubble_o),     8'd0);
        chk({name, ".flush"},      8'(flush_o),      8'd0);
        chk({name, ".stall_cnt"},  stall_cnt_o,      8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rs rt rd rw mr urs urt br | fa fb stall flush cnt
        tbl[0]  = mk(1, 2, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // add $3
        tbl[1]  = mk(3, 4, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // sub reads $3
        tbl[2]  = nop(1, 0, 0);                               // sub in EX: A from EX/MEM
        tbl[3]  = mk(1, 2, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // add $3
        tbl[4]  = nop(0, 0, 0);
        tbl[5]  = mk(7, 3, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // or reads $3 as rt
        tbl[6]  = nop(0, 2, 0);                               // or in EX: B from MEM/WB
        tbl[7]  = mk(1, 2, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // add $3
        tbl[8]  = mk(1, 2, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);  // add $3 again
        tbl[9]  = mk(3, 3, 10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0); // reader of $3
        tbl[10] = nop(1, 1, 0);                               // newest wins
        tbl[11] = mk(1, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // lw $4
        tbl[12] = mk(4, 2, 7, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);  // add reads $4: stall
        tbl[13] = mk(4, 2, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);  // add re-presented
        tbl[14] = nop(2, 0, 1);                               // add in EX: A from MEM/WB
        tbl[15] = mk(1, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);  // lw $4
        tbl[16] = mk(4, 2, 7, 1, 0, 1, 1, 1, 0, 0, 0, 1, 1);  // load-use with taken branch
        tbl[17] = nop(0, 0, 1);
        tbl[18] = mk(1, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);  // add $0
        tbl[19] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);  // lw $0
        tbl[20] = mk(0, 0, 8, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);  // reads $0 behind lw $0
        tbl[21] = nop(0, 0, 1);

        rst_i = 1'b0;
        id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0;
        id_use_rs_i = 1'b0; id_use_rt_i = 1'b0;
        ex_branch_taken_i = 1'b0;

        repeat (2) @(negedge clk_i);
        chk_reset_outputs("in_reset");
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i], $sformatf("row%0d", i), 1'b1);
            sample();
        end

        // 300 load-use stalls: count saturates at 255
        for (int i = 0; i < 300; i++) begin
            int c0, c1;
            c0 = (1 + i > 255) ? 255 : 1 + i;
            c1 = (2 + i > 255) ? 255 : 2 + i;
            drive(mk(1, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, c0), $sformatf("sat%0d.lw", i), 1'b0);
            sample();
            drive(mk(4, 2, 7, 1, 0, 1, 1, 0, 0, 0, 1, 0, c0), $sformatf("sat%0d.use", i), 1'b0);
            sample();
            drive(mk(4, 2, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, c1), $sformatf("sat%0d.held", i), 1'b0);
            sample();
        end
        drive(nop(0, 0, 255), "sat_end", 1'b0);
        sample();

        // Reset asserted in the middle of a load-use stall
        drive(mk(1, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 255), "rst.lw", 1'b1);
        sample();
        drive(mk(4, 2, 7, 1, 0, 1, 1, 0, 0, 0, 1, 0, 255), "rst.use", 1'b0);
        sample();
        #2;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("rst_mid_stall");
        ex_branch_taken_i = 1'b1;
        #1;
        chk("rst_branch.flush", 8'(flush_o), 8'd0);
        chk("rst_branch.pc_write", 8'(pc_write_o), 8'd1);
        ex_branch_taken_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("rst_after_edge");
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("rst_release");
        @(posedge clk_i);
        #1;
        chk("rst_post_edge.stall_cnt", stall_cnt_o, 8'd0);
        chk("rst_post_edge.bubble", 8'(bubble_o), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
